// File: rtl/synth_voice_pkg.sv
// rtl/synth_voice_pkg.sv - shared types and widths for the voice allocator
package synth_voice_pkg;

    localparam int FREQ_W  = 12;
    localparam int ATTEN_W = 4;
    localparam int AGE_W   = 8;

    localparam logic [ATTEN_W-1:0] ATTEN_MAX = 4'd15;
    localparam logic [AGE_W-1:0]   AGE_MAX   = 8'd255;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } voice_state_t;

    typedef enum logic [1:0] {
        C_WAIT,
        C_SEARCH,
        C_COMMIT
    } ctrl_state_t;

    // What the commit cycle does with the slot picked during the search
    typedef enum logic [1:0] {
        ACT_DROP,
        ACT_ATTACK,
        ACT_RELEASE
    } alloc_act_t;

endpackage

// File: rtl/voice_envelope.sv
// rtl/voice_envelope.sv - per-slot attack/sustain/release envelope with age counter
module voice_envelope
    import synth_voice_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               load_attack,
    input  logic               load_release,
    input  logic               hold,
    input  logic               restart,
    output voice_state_t       state,
    output logic [ATTEN_W-1:0] atten,
    output logic [AGE_W-1:0]   age
);

    voice_state_t       state_nxt;
    logic [ATTEN_W-1:0] atten_nxt;
    logic [AGE_W-1:0]   age_nxt;

    // Slot state, attenuation and age registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            atten <= ATTEN_MAX;
            age   <= '0;
        end else begin
            state <= state_nxt;
            atten <= atten_nxt;
            age   <= age_nxt;
        end
    end

    // Loads from the controller take priority; otherwise step once per tick unless held
    always_comb begin
        state_nxt = state;
        atten_nxt = atten;
        age_nxt   = age;
        if (load_attack) begin
            state_nxt = ATTACK;
            age_nxt   = '0;
            if (restart) begin
                atten_nxt = ATTEN_MAX;
            end
        end else if (load_release) begin
            state_nxt = RELEASE;
        end else if (tick && !hold) begin
            if (age != AGE_MAX) begin
                age_nxt = age + 1'b1;
            end
            case (state)
                ATTACK: begin
                    if (atten <= ATTEN_W'(1)) begin
                        atten_nxt = '0;
                        state_nxt = SUSTAIN;
                    end else begin
                        atten_nxt = atten - 1'b1;
                    end
                end
                RELEASE: begin
                    if (atten == ATTEN_MAX) begin
                        state_nxt = IDLE;
                    end else begin
                        atten_nxt = atten + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator, voice stealing enabled by VOICE_STEAL_EN
module voice_allocator
    import synth_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int TICK_DIV   = 480
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_en,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_note_on,
    input  logic [FREQ_W-1:0]              req_freq,
    output logic [FREQ_W*NUM_VOICES-1:0]   voice_freq,
    output logic [NUM_VOICES-1:0]          voice_stop,
    output logic [ATTEN_W*NUM_VOICES-1:0]  voice_volume,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic                           dropped
);

    localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    // Envelope tick divider
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = sample_en && (tick_cnt == CNT_LAST);

    // Count sample pulses, wrapping on the tick
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (sample_en) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    // Slot storage
    voice_state_t                          slot_state [NUM_VOICES];
    logic [NUM_VOICES-1:0][ATTEN_W-1:0]    slot_atten;
    logic [NUM_VOICES-1:0][AGE_W-1:0]      slot_age;
    logic [NUM_VOICES-1:0][FREQ_W-1:0]     slot_freq;
    logic [NUM_VOICES-1:0]                 load_attack;
    logic [NUM_VOICES-1:0]                 load_release;

    // Controller and request registers
    ctrl_state_t        cstate;
    ctrl_state_t        cnext;
    logic               ready_q;
    logic               dropped_q;
    logic               req_on_q;
    logic [FREQ_W-1:0]  req_freq_q;
    alloc_act_t         sel_act_q;
    logic [SLOT_W-1:0]  sel_slot_q;
    logic               sel_restart_q;
    logic               accept;

    assign accept = req_valid && ready_q;

    // Search results
    logic               hit_on;
    logic               hit_idle;
    logic               hit_off;
    logic [SLOT_W-1:0]  idx_on;
    logic [SLOT_W-1:0]  idx_idle;
    logic [SLOT_W-1:0]  idx_off;
    alloc_act_t         act_d;
    logic [SLOT_W-1:0]  slot_d;
    logic               restart_d;

    // Lowest-index matches for retrigger, free slot and note-off
    always_comb begin
        hit_on   = 1'b0;
        hit_idle = 1'b0;
        hit_off  = 1'b0;
        idx_on   = '0;
        idx_idle = '0;
        idx_off  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!hit_on && slot_state[i] != IDLE && slot_freq[i] == req_freq_q) begin
                hit_on = 1'b1;
                idx_on = SLOT_W'(i);
            end
            if (!hit_idle && slot_state[i] == IDLE) begin
                hit_idle = 1'b1;
                idx_idle = SLOT_W'(i);
            end
            if (!hit_off && (slot_state[i] == ATTACK || slot_state[i] == SUSTAIN)
                && slot_freq[i] == req_freq_q) begin
                hit_off = 1'b1;
                idx_off = SLOT_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic               hit_rel;
    logic [SLOT_W-1:0]  idx_rel;
    logic [SLOT_W-1:0]  idx_old;
    logic [ATTEN_W-1:0] best_rel_atten;
    logic [AGE_W-1:0]   best_age;

    // Steal candidates: quietest releasing slot, else oldest slot; strict compare keeps lowest index on ties
    always_comb begin
        hit_rel        = 1'b0;
        idx_rel        = '0;
        idx_old        = '0;
        best_rel_atten = '0;
        best_age       = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (slot_state[i] == RELEASE && (!hit_rel || slot_atten[i] > best_rel_atten)) begin
                hit_rel        = 1'b1;
                idx_rel        = SLOT_W'(i);
                best_rel_atten = slot_atten[i];
            end
            if (i == 0 || slot_age[i] > best_age) begin
                idx_old  = SLOT_W'(i);
                best_age = slot_age[i];
            end
        end
    end
`else
    logic unused_age;
    assign unused_age = ^slot_age;
`endif

    // Decide what the commit cycle will do with the registered request
    always_comb begin
        act_d     = ACT_DROP;
        slot_d    = '0;
        restart_d = 1'b0;
        if (req_on_q) begin
            if (req_freq_q == '0) begin
                act_d = ACT_DROP;
            end else if (hit_on) begin
                act_d  = ACT_ATTACK;
                slot_d = idx_on;
            end else if (hit_idle) begin
                act_d     = ACT_ATTACK;
                slot_d    = idx_idle;
                restart_d = 1'b1;
            end else begin
`ifdef VOICE_STEAL_EN
                act_d     = ACT_ATTACK;
                slot_d    = hit_rel ? idx_rel : idx_old;
                restart_d = 1'b1;
`endif
            end
        end else if (hit_off) begin
            act_d  = ACT_RELEASE;
            slot_d = idx_off;
        end
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (reset) begin
            cstate <= C_WAIT;
        end else begin
            cstate <= cnext;
        end
    end

    // Controller next state: one request walks wait -> search -> commit
    always_comb begin
        cnext = cstate;
        case (cstate)
            C_WAIT:   if (accept) cnext = C_SEARCH;
            C_SEARCH: cnext = C_COMMIT;
            C_COMMIT: cnext = C_WAIT;
            default:  cnext = C_WAIT;
        endcase
    end

    // Controller outputs: per-slot load strobes during commit
    always_comb begin
        load_attack  = '0;
        load_release = '0;
        if (cstate == C_COMMIT) begin
            if (sel_act_q == ACT_ATTACK) begin
                load_attack[sel_slot_q] = 1'b1;
            end else if (sel_act_q == ACT_RELEASE) begin
                load_release[sel_slot_q] = 1'b1;
            end
        end
    end

    // Registered handshake, drop pulse, captured request and search decision
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q       <= 1'b0;
            dropped_q     <= 1'b0;
            req_on_q      <= 1'b0;
            req_freq_q    <= '0;
            sel_act_q     <= ACT_DROP;
            sel_slot_q    <= '0;
            sel_restart_q <= 1'b0;
        end else begin
            ready_q   <= (cnext == C_WAIT);
            dropped_q <= (cstate == C_SEARCH) && (act_d == ACT_DROP);
            if (accept) begin
                req_on_q   <= req_note_on;
                req_freq_q <= req_freq;
            end
            if (cstate == C_SEARCH) begin
                sel_act_q     <= act_d;
                sel_slot_q    <= slot_d;
                sel_restart_q <= restart_d;
            end
        end
    end

    // Slot frequency written on note-on commit, held through release and idle
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_freq <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (load_attack[i]) begin
                    slot_freq[i] <= req_freq_q;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        voice_envelope u_env (
            .clk          (clk),
            .reset        (reset),
            .tick         (tick),
            .load_attack  (load_attack[g]),
            .load_release (load_release[g]),
            .hold         (load_attack[g] | load_release[g]),
            .restart      (sel_restart_q),
            .state        (slot_state[g]),
            .atten        (slot_atten[g]),
            .age          (slot_age[g])
        );
        assign voice_stop[g]   = (slot_state[g] == IDLE);
        assign voice_active[g] = (slot_state[g] != IDLE);
    end

    assign voice_freq   = slot_freq;
    assign voice_volume = slot_atten;
    assign req_ready    = ready_q;
    assign dropped      = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed self-checking bench for voice_allocator
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int TD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic        req_valid;
    logic        req_ready;
    logic        req_note_on;
    logic [11:0] req_freq;
    logic [47:0] voice_freq;
    logic [3:0]  voice_stop;
    logic [15:0] voice_volume;
    logic [3:0]  voice_active;
    logic        dropped;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV), .TICK_DIV(TD)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_en    (sample_en),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_note_on  (req_note_on),
        .req_freq     (req_freq),
        .voice_freq   (voice_freq),
        .voice_stop   (voice_stop),
        .voice_volume (voice_volume),
        .voice_active (voice_active),
        .dropped      (dropped)
    );

    typedef struct {
        logic on;
        int   freq;
        logic drop;
        int   active;
        int   slot;
        int   freq_e;
        int   vol_e;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        sample_en = 1'b0;
        req_note_on = 1'b0;
        req_freq = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic ticks(input int n);
        sample_en = 1'b1;
        repeat (n * TD) cyc();
        sample_en = 1'b0;
    endtask

    function automatic int fq(input int s);
        return int'(voice_freq[12*s +: 12]);
    endfunction

    function automatic int vol(input int s);
        return int'(voice_volume[4*s +: 4]);
    endfunction

    task automatic send(input logic on, input int f, output logic drop);
        int w = 0;
        drop = 1'b0;
        while (!req_ready && w < 10) begin
            cyc();
            w++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_note_on = on;
        req_freq = 12'(f);
        cyc();
        req_valid = 1'b0;
        cyc();
        drop = dropped;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic d;
        int   acc [4];
        int   k;
        int   fr [4];

        tv[0] = '{1'b1, 440, 1'b0, 4'b0001, 0, 440, 15};
        tv[1] = '{1'b1, 440, 1'b0, 4'b0001, 0, 440, 15};
        tv[2] = '{1'b0, 880, 1'b1, 4'b0001, 0, 440, 15};
        tv[3] = '{1'b1, 0,   1'b1, 4'b0001, 1, 0,   15};
        tv[4] = '{1'b1, 220, 1'b0, 4'b0011, 1, 220, 15};
        tv[5] = '{1'b1, 330, 1'b0, 4'b0111, 2, 330, 15};
        tv[6] = '{1'b0, 220, 1'b0, 4'b0111, 1, 220, 15};
        tv[7] = '{1'b1, 550, 1'b0, 4'b1111, 3, 550, 15};
`ifdef VOICE_STEAL_EN
        tv[8] = '{1'b1, 660, 1'b0, 4'b1111, 1, 660, 15};
`else
        tv[8] = '{1'b1, 660, 1'b1, 4'b1111, 1, 220, 15};
`endif

        // reset values while reset is held
        reset = 1'b1;
        req_valid = 1'b0;
        sample_en = 1'b0;
        req_note_on = 1'b0;
        req_freq = '0;
        cyc();
        cyc();
        chk("rst_freq", int'(voice_freq == 48'd0), 1);
        chk("rst_stop", voice_stop, 4'hF);
        chk("rst_volume", voice_volume, 16'hFFFF);
        chk("rst_active", voice_active, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_ready", req_ready, 0);
        reset = 1'b0;
        cyc();
        chk("ready_after_reset", req_ready, 1);

        // table of back-to-back requests without ticks
        for (int i = 0; i < 9; i++) begin
            send(tv[i].on, tv[i].freq, d);
            chk($sformatf("vec%0d_drop", i), d, tv[i].drop);
            chk($sformatf("vec%0d_active", i), voice_active, tv[i].active);
            chk($sformatf("vec%0d_freq", i), fq(tv[i].slot), tv[i].freq_e);
            chk($sformatf("vec%0d_vol", i), vol(tv[i].slot), tv[i].vol_e);
            chk($sformatf("vec%0d_dropped_clear", i), dropped, 0);
        end

        // full envelope on slot 0
        do_reset();
        send(1'b1, 440, d);
        chk("env_start_vol", vol(0), 15);
        chk("env_start_stop", voice_stop[0], 0);
        chk("env_start_freq", fq(0), 440);
        ticks(14);
        chk("env_attack14", vol(0), 1);
        ticks(1);
        chk("env_attack15", vol(0), 0);
        ticks(2);
        chk("env_sustain", vol(0), 0);
        send(1'b0, 440, d);
        chk("env_off_drop", d, 0);
        ticks(15);
        chk("env_release15_vol", vol(0), 15);
        chk("env_release15_active", voice_active, 4'b0001);
        ticks(1);
        chk("env_idle_active", voice_active, 0);
        chk("env_idle_stop", voice_stop[0], 1);
        chk("env_idle_freq", fq(0), 440);
        chk("env_idle_vol", vol(0), 15);

        // steal by age: slot 0 is oldest, nothing releasing
        do_reset();
        send(1'b1, 220, d);
        ticks(1);
        send(1'b1, 330, d);
        ticks(1);
        send(1'b1, 440, d);
        ticks(1);
        send(1'b1, 550, d);
        ticks(1);
        chk("age_pre_vol0", vol(0), 11);
        send(1'b1, 660, d);
`ifdef VOICE_STEAL_EN
        chk("steal_drop", d, 0);
        chk("steal_freq0", fq(0), 660);
        chk("steal_vol0", vol(0), 15);
`else
        chk("nosteal_drop", d, 1);
        chk("nosteal_freq0", fq(0), 220);
        chk("nosteal_vol0", vol(0), 11);
`endif
        chk("steal_freq1", fq(1), 330);
        chk("steal_active", voice_active, 4'b1111);

        // valid held high across four requests
        do_reset();
        fr = '{100, 200, 300, 400};
        k = 0;
        req_valid = 1'b1;
        req_note_on = 1'b1;
        req_freq = 12'(fr[0]);
        for (int c = 0; c < 20; c++) begin
            if (req_valid && req_ready) begin
                acc[k] = c;
                k++;
            end
            cyc();
            if (k < 4) req_freq = 12'(fr[k]);
            else req_valid = 1'b0;
        end
        chk("tput_count", k, 4);
        if (k == 4) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("tput_gap%0d", i), acc[i+1] - acc[i], 3);
            end
        end
        chk("tput_active", voice_active, 4'b1111);
        chk("tput_freq3", fq(3), 400);

        // tick landing on the commit edge of a retrigger
        do_reset();
        send(1'b1, 440, d);
        send(1'b1, 330, d);
        ticks(3);
        chk("align_pre_vol0", vol(0), 12);
        chk("align_pre_vol1", vol(1), 12);
        req_valid = 1'b1;
        req_note_on = 1'b1;
        req_freq = 12'd440;
        cyc();
        req_valid = 1'b0;
        sample_en = 1'b1;
        cyc();
        cyc();
        sample_en = 1'b0;
        chk("align_vol0_held", vol(0), 12);
        chk("align_vol1_step", vol(1), 11);
        chk("align_active", voice_active, 4'b0011);

        // reset during release with a request in flight
        do_reset();
        send(1'b1, 440, d);
        ticks(15);
        send(1'b0, 440, d);
        ticks(3);
        chk("midrel_vol", vol(0), 3);
        req_valid = 1'b1;
        req_note_on = 1'b1;
        req_freq = 12'd550;
        cyc();
        req_valid = 1'b0;
        reset = 1'b1;
        cyc();
        chk("midrst_freq", int'(voice_freq == 48'd0), 1);
        chk("midrst_stop", voice_stop, 4'hF);
        chk("midrst_volume", voice_volume, 16'hFFFF);
        chk("midrst_active", voice_active, 0);
        chk("midrst_dropped", dropped, 0);
        chk("midrst_ready", req_ready, 0);
        reset = 1'b0;
        cyc();
        chk("postrst_ready", req_ready, 1);
        chk("postrst_dropped", dropped, 0);
        cyc();
        cyc();
        chk("postrst_active", voice_active, 0);
        chk("postrst_dropped2", dropped, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice controller that shares a fixed pool of triangle-wave oscillators among note requests. It accepts note-on/note-off requests over a valid/ready handshake and assigns each note to an oscillator slot. Per slot, it drives frequency, stop and attenuation (volume shift), sequencing an attack/sustain/release envelope in steps of the 4-bit attenuation. It sits between the key/MIDI decoder and the oscillator bank, ahead of the audio mixer.

## Interface
- NUM_VOICES, 4, number of oscillator slots (2..8)
- TICK_DIV, 480, sample_en pulses per envelope tick (100 Hz at 48 kHz)

- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- sample_en  in  1  one-cycle pulse per audio sample
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_note_on  in  1  1 = note-on, 0 = note-off
- req_freq  in  12  note frequency in Hz (oscillator freq code)
- voice_freq  out  12*NUM_VOICES  per-slot frequency; slot i at [12i+11:12i]
- voice_stop  out  NUM_VOICES  per-slot oscillator stop
- voice_volume  out  4*NUM_VOICES  per-slot attenuation shift (0 loudest, 15 quietest)
- voice_active  out  NUM_VOICES  slot is not IDLE
- dropped  out  1  one-cycle pulse when a request is discarded

## Operation
- Reset values: voice_freq 0, voice_stop all 1, voice_volume all 15, voice_active 0, dropped 0, req_ready 0. req_ready is 1 from the first cycle after reset deasserts.
- Tick: counter of sample_en pulses; one-cycle tick when the count reaches TICK_DIV-1, then the counter wraps to 0.
- Per-slot FSM:
  - IDLE: stop=1, atten=15.
  - ATTACK: stop=0. atten decrements by 1 per tick. At 0 -> SUSTAIN.
  - SUSTAIN: atten holds at 0.
  - RELEASE: atten increments by 1 per tick. On the tick where atten is already 15 -> IDLE.
- Per-slot age: 8-bit counter, cleared on assignment, increments per tick, saturates at 255.
- Controller FSM, request path:
  - C_WAIT (ready=1). Request accepted on req_valid & req_ready.
  - C_SEARCH: match and allocation computed from registered request.
  - C_COMMIT: slot outputs written.
  - Returns to C_WAIT.
- Note-on:
  - Non-IDLE slot with equal freq -> retrigger that slot: ATTACK from current atten, age 0.
  - Else lowest-index IDLE slot -> write freq, ATTACK from atten 15.
  - Else steal (see Configuration).
  - req_freq 0 -> discarded, dropped pulses.
- Note-off: lowest-index slot in ATTACK or SUSTAIN with equal freq -> RELEASE. No match -> discarded, dropped pulses.
- voice_freq is held unchanged through RELEASE and IDLE.

## Timing
- Request accepted at edge N. Slot outputs change at edge N+2. req_ready is 0 for the cycles after N and N+1, and 1 again after edge N+2. Maximum throughput is one request per 3 cycles.
- dropped pulses in the C_COMMIT cycle.
- Tick coinciding with a commit to the same slot: the commit wins, and that slot's envelope/age skip the tick. Other slots step normally.
- reset mid-operation: all slots return to IDLE and any pending request is lost, with no dropped pulse.
- All outputs are registered. There is no combinational path from req_valid to req_ready.

## Configuration
- VOICE_STEAL_EN defined: a note-on with no matching or IDLE slot steals a slot.
  - First choice: a RELEASE slot with the highest atten (ties -> lowest index).
  - Otherwise: the slot with the greatest age (ties -> lowest index).
  - The stolen slot is overwritten with the new freq, enters ATTACK from atten 15, age 0.
- VOICE_STEAL_EN undefined: such a note-on is discarded and dropped pulses.

## Structure
- Package synth_voice_pkg:
  - voice_state_t enum (IDLE, ATTACK, SUSTAIN, RELEASE)
  - ctrl_state_t enum (C_WAIT, C_SEARCH, C_COMMIT)
  - FREQ_W=12, ATTEN_W=4, ATTEN_MAX=15, AGE_W=8
- Sub-module voice_envelope, instantiated NUM_VOICES times:
  - Holds the slot FSM, atten and age.
  - Inputs: tick, load_attack, load_release, hold.
  - Outputs: state, atten, age.
- Allocation search and tick divider live in voice_allocator.

## Test plan
- Reset, then note-on 440: slot 0 freq 440, stop 0 at N+2. atten goes 15->0 over 15 ticks, then SUSTAIN. voice_active=0001.
- Note-off 440 while in SUSTAIN: atten 0->15 over 15 ticks. After the 16th tick slot 0 is IDLE with stop=1, and freq stays 440.
- Note-on 220, 330, 440, 550, then 660 with VOICE_STEAL_EN defined: slot 0 (oldest) is reassigned to 660 with atten 15. Without the macro, dropped pulses and the slots are unchanged.
- Note-on 440 twice: the second retriggers slot 0 only, and voice_active stays 0001. Note-off 880 (no match): dropped pulses and the slots are unchanged.
- Hold req_valid high with 4 back-to-back requests: exactly one acceptance per 3 cycles, and req_ready is never high in C_SEARCH or C_COMMIT.
- Tick aligned with a note-on commit to an ATTACK slot: that slot's atten is not decremented that tick. Assert reset mid-release: all outputs return to their reset values the next cycle.
